// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin computed LSB first, one bit per clock.
// Define SERIAL_SUB_ADD_MODE_EN to add an op input selecting a + b + bin (carry on bout).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    // WIDTH >= 2, so the counter is at least one bit and spans 0..WIDTH-1
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, bout_q, busy_q, done_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             op_q;
`endif

    logic             bit_d, br_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        bit_d = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (op_q) br_d = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & br_q);
`endif
        res_d = {bit_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            op_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        op_q    <= op;
`endif
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Only the final step publishes; partial results stay internal
                    if (cnt_q == LAST) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences,
// exhaustive sweep and random operations against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, bin = 1'b0, op = 1'b0;
    logic [W-1:0] a = '0, b = '0, diff;
    logic         bout, busy, done;
    int           tests = 0, fails = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op(op),
`endif
        .diff(diff), .bout(bout), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, result {borrow/carry, low W bits}
    function automatic logic [W:0] model(input int x, input int y, input int c, input logic add);
        int r;
        if (add) begin
            r = x + y + c;
            return {1'(r >= (1 << W)), W'(r)};
        end
        r = x - y - c;
        return {1'(r < 0), W'(r)};
    endfunction

    // One full operation from IDLE; inputs are scrambled while busy.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                         input logic tm, input string nm, output logic [W:0] res);
        int         lat;
        logic [W:0] prev;
        logic       hold;
        @(posedge clk); #1;
        a = ta; b = tb2; bin = tc; op = tm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        op = 1'($urandom);
        prev = {bout, diff};
        hold = 1'b1;
        lat  = -1;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
            if ({bout, diff} !== prev || !busy) hold = 1'b0;
        end
        res = {bout, diff};
        chk({nm, " latency"}, lat, W);
        chk({nm, " hold"}, int'(hold), 1);
        @(posedge clk); #1;
        chk({nm, " idle"}, int'({busy, done}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[7];
        logic [W:0] res;
        int         nd, lat;

        vecs[0] = '{4'd7,  4'd3,  1'b0, 4'h4, 1'b0};
        vecs[1] = '{4'd3,  4'd7,  1'b0, 4'hC, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'd5,  4'd5,  1'b0, 4'h0, 1'b0};
        vecs[4] = '{4'd15, 4'd0,  1'b1, 4'hE, 1'b0};
        vecs[5] = '{4'd0,  4'd15, 1'b0, 4'h1, 1'b1};
        vecs[6] = '{4'd8,  4'd8,  1'b1, 4'hF, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        chk("rst diff", int'(diff), 0);
        chk("rst bout", int'(bout), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        #20 rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, $sformatf("vec%0d", i), res);
            chk($sformatf("vec%0d result", i), int'(res), int'({vecs[i].bo, vecs[i].d}));
        end

        // start held high through SHIFT/DONE with operands zeroed after accept
        @(posedge clk); #1;
        a = 4'd9; b = 4'd2; bin = 1'b0; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("held busy", int'(busy), 1);
        a = '0; b = '0;
        nd = 0;
        res = '0;
        for (int i = 1; i <= W + 1; i++) begin
            @(posedge clk); #1;
            if (done) begin nd++; res = {bout, diff}; end
        end
        chk("held done count", nd, 1);
        chk("held result", int'(res), 5'h07);
        chk("held idle gap", int'(busy), 0);
        @(posedge clk); #1;
        chk("held reaccept", int'(busy), 1);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk("b2b latency", lat, W);
        chk("b2b result", int'({bout, diff}), 0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of SHIFT
        do_op(4'd7, 4'd3, 1'b0, 1'b0, "pre", res);
        chk("pre result", int'(res), 5'h04);
        @(posedge clk); #1;
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid rst diff", int'(diff), 0);
        chk("mid rst bout", int'(bout), 0);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst done", int'(done), 0);
        a = 4'd5; b = 4'd5; bin = 1'b0; start = 1'b1;
        nd = 0;
        @(posedge clk); #1; nd += int'(done);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        nd += int'(done);
        chk("post rst accept", int'(busy), 1);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= W + 4; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        chk("post rst no stray done", nd, 0);
        chk("post rst latency", lat, W);
        chk("post rst result", int'({bout, diff}), 0);
        @(posedge clk); #1;

`ifdef SERIAL_SUB_ADD_MODE_EN
        do_op(4'd9, 4'd8, 1'b0, 1'b1, "add", res);
        chk("add result", int'(res), 5'h11);
        do_op(4'd9, 4'd8, 1'b0, 1'b0, "sub", res);
        chk("sub result", int'(res), 5'h01);
`endif

        for (int m = 0; m < 2; m++) begin
`ifndef SERIAL_SUB_ADD_MODE_EN
            if (m == 1) break;
`endif
            for (int x = 0; x < (1 << W); x++)
                for (int y = 0; y < (1 << W); y++)
                    for (int c = 0; c < 2; c++) begin
                        do_op(W'(x), W'(y), 1'(c), 1'(m), "sweep", res);
                        if (res !== model(x, y, c, 1'(m)))
                            $display("  sweep op=%0d a=%0d b=%0d bin=%0d", m, x, y, c);
                        chk("sweep result", int'(res), int'(model(x, y, c, 1'(m))));
                    end
        end

        for (int k = 0; k < 100; k++) begin
            int   x, y, c;
            logic m;
            x = int'($urandom_range((1 << W) - 1));
            y = int'($urandom_range((1 << W) - 1));
            c = int'($urandom_range(1));
`ifdef SERIAL_SUB_ADD_MODE_EN
            m = 1'($urandom);
`else
            m = 1'b0;
`endif
            do_op(W'(x), W'(y), 1'(c), m, "rand", res);
            chk($sformatf("rand a=%0d b=%0d bin=%0d op=%0d", x, y, c, m), int'(res),
                int'(model(x, y, c, m)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation, sampled in IDLE only.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 SHALL have port bin  input  1  borrow-in, captured when start is accepted.
REQ-008 SHALL have port diff  output  WIDTH  result a-b-bin, registered.
REQ-009 SHALL have port bout  output  1  borrow-out (1 when a < b+bin unsigned), registered.
REQ-010 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-011 SHALL have port done  output  1  single-cycle pulse marking diff/bout valid.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start=1; SHIFT->DONE after WIDTH bit-steps; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL, on the edge accepting start, load a and b into shift registers, load bin into the borrow flop, clear the bit counter, and clear the result register.
REQ-014 SHALL, on each SHIFT edge, process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0)|(~(a0^b0)&br); d shifts into the result MSB, operands shift right.
REQ-015 SHALL update diff and bout on the edge leaving SHIFT; done SHALL be high for exactly the cycle following edge WIDTH after the accepting edge (latency WIDTH clocks).
REQ-016 SHALL hold diff and bout stable from done until the next accepted start; they SHALL NOT change during SHIFT (intermediate bits are kept internal).
REQ-017 SHALL ignore start while busy=1, including the DONE cycle; a and b changes during busy SHALL NOT affect the result.
REQ-018 SHALL produce results that wrap modulo 2^WIDTH, with bout the borrow out of bit WIDTH-1.
REQ-019 SHALL accept a start asserted in the cycle after DONE, i.e. in IDLE (back-to-back throughput one operation per WIDTH+2 cycles).

Reset
REQ-020 SHALL, on rst_n=0, immediately force state IDLE, diff=0, bout=0, busy=0, done=0, counter/shift/borrow registers 0, independent of clk.
REQ-021 SHALL abandon any in-flight operation on reset with no done pulse, and accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-022 SHALL, with macro SERIAL_SUB_ADD_MODE_EN defined, add input port op (1 bit, captured at start): op=0 subtracts as above; op=1 computes a+b+bin with carry reported on bout (carry_next = a0&b0 | (a0^b0)&c).
REQ-023 SHALL, without SERIAL_SUB_ADD_MODE_EN, have no op port and perform subtraction only.

Verification
REQ-024 SHALL cover: WIDTH=4, a=7, b=3, bin=0, start one cycle -> done high on 4th edge after accept, diff=4'h4, bout=0, busy low after DONE.
REQ-025 SHALL cover: a=3, b=7, bin=0 -> diff=4'hC, bout=1; then a=0, b=0, bin=1 -> diff=4'hF, bout=1.
REQ-026 SHALL cover: start held high plus a/b changed to 0 during SHIFT of a=9,b=2 -> single result diff=4'h7, bout=0, one done pulse, next op accepted only from IDLE.
REQ-027 SHALL cover: rst_n pulsed low mid-SHIFT (asynchronously, between edges) -> diff=0, bout=0, busy=0 immediately, no done pulse; subsequent a=5,b=5 -> diff=0, bout=0.
REQ-028 SHALL cover, with SERIAL_SUB_ADD_MODE_EN: op=1, a=9, b=8, bin=0 -> diff=4'h1, bout=1; op=0 same operands -> diff=4'h1, bout=0.
REQ-029 SHALL cover: exhaustive WIDTH=4 sweep of a, b, bin compared against (a-b-bin) mod 16 and borrow model, zero mismatches.
